vdc_host_seq: RTL and testbench

Host-side initiator for the VDC two-port register interface (address port rs=0, data port rs=1). Accepts single register read/write requests from an internal master (boot loader, debug port or CPU shim) and turns them into the VDC bus sequence: select register, poll the status ready bit when required, then access the data port. Sits between the request source and the VDC `cs/rs/we/db_in/db_out/enableBus` pins, on the same clock as the VDC.

---
 rtl/vdc_host_seq.sv | 204 ++++++++++++++++++++
 tb/tb_vdc_host_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vdc_host_seq.sv
// Host-side sequencer for the VDC address/data register port pair: select, optional status poll, data access.
// Optional feature: define VDC_HOST_ADDR_CACHE_EN to skip SEL when the register matches the last selected one.
module vdc_host_seq #(
  parameter int POLL_TIMEOUT = 1023,
  parameter int POLL_ALL     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_en,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [5:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       vdc_cs,
  output logic       vdc_rs,
  output logic       vdc_we,
  output logic [7:0] vdc_wdata,
  input  logic [7:0] vdc_rdata,
  output logic [2:0] dbg_state
);

  // Request handshake: a request transfers on a cycle where req_valid and req_ready are both 1;
  // req_ready is only high in IDLE, and rsp_valid is a single-cycle pulse carrying rsp_err/rsp_rdata.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    POLL = 3'd2,
    PSMP = 3'd3,
    DATA = 3'd4,
    DSMP = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(POLL_TIMEOUT);

  state_t      state_q, state_d;
  logic        lat_we_q, lat_we_d;
  logic [5:0]  lat_reg_q, lat_reg_d;
  logic [7:0]  lat_wdata_q, lat_wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        cs_q, cs_d;
  logic        rs_q, rs_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;

  logic        cache_hit;

`ifdef VDC_HOST_ADDR_CACHE_EN
  logic        cache_vld_q, cache_vld_d;
  logic [5:0]  cache_reg_q, cache_reg_d;
  assign cache_hit = cache_vld_q && (cache_reg_q == req_reg);
`else
  assign cache_hit = 1'b0;
`endif

  // Busy-prone registers (VRAM transfer / DMA group) need the ready bit before data access.
  function automatic logic needs_poll(input logic [5:0] r);
    return (POLL_ALL != 0) || (r == 6'd18) || (r == 6'd19) ||
           ((r >= 6'd30) && (r <= 6'd33));
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_we_q    <= 1'b0;
      lat_reg_q   <= 6'd0;
      lat_wdata_q <= 8'd0;
      cnt_q       <= 16'd0;
      err_q       <= 1'b0;
      rdata_q     <= 8'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      cs_q        <= 1'b0;
      rs_q        <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= 8'd0;
`ifdef VDC_HOST_ADDR_CACHE_EN
      cache_vld_q <= 1'b0;
      cache_reg_q <= 6'd0;
`endif
    end else begin
      state_q     <= state_d;
      lat_we_q    <= lat_we_d;
      lat_reg_q   <= lat_reg_d;
      lat_wdata_q <= lat_wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      cs_q        <= cs_d;
      rs_q        <= rs_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
`ifdef VDC_HOST_ADDR_CACHE_EN
      cache_vld_q <= cache_vld_d;
      cache_reg_q <= cache_reg_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    lat_we_d    = lat_we_q;
    lat_reg_d   = lat_reg_q;
    lat_wdata_d = lat_wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
`ifdef VDC_HOST_ADDR_CACHE_EN
    cache_vld_d = cache_vld_q;
    cache_reg_d = cache_reg_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          lat_we_d    = req_we;
          lat_reg_d   = req_reg;
          lat_wdata_d = req_wdata;
          cnt_d       = 16'd0;
          err_d       = 1'b0;
          rdata_d     = 8'd0;
          if (cache_hit) state_d = needs_poll(req_reg) ? POLL : DATA;
          else           state_d = SEL;
        end
      end
      SEL: begin
        if (bus_en) begin
          state_d = needs_poll(lat_reg_q) ? POLL : DATA;
`ifdef VDC_HOST_ADDR_CACHE_EN
          cache_vld_d = 1'b1;
          cache_reg_d = lat_reg_q;
`endif
        end
      end
      POLL: state_d = PSMP;
      PSMP: begin
        if (vdc_rdata[7]) begin
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TIMEOUT) begin
            state_d = DONE;
            err_d   = 1'b1;
`ifdef VDC_HOST_ADDR_CACHE_EN
            cache_vld_d = 1'b0;
`endif
          end else begin
            state_d = POLL;
          end
        end
      end
      DATA: begin
        if (!lat_we_q)   state_d = DSMP;
        else if (bus_en) state_d = DONE;
      end
      DSMP: begin
        rdata_d = vdc_rdata;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: decoded from the next state so every pin is a flop aligned with its state.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
    rsp_err_d   = (state_d == DONE) && err_d;
    cs_d        = (state_d == SEL) || (state_d == POLL) || (state_d == DATA);
    rs_d        = (state_d == DATA);
    we_d        = (state_d == SEL) || ((state_d == DATA) && lat_we_d);
    wdata_d     = 8'd0;
    if (state_d == SEL)                   wdata_d = {2'b00, lat_reg_d};
    else if ((state_d == DATA) && lat_we_d) wdata_d = lat_wdata_d;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;
  assign vdc_cs    = cs_q;
  assign vdc_rs    = rs_q;
  assign vdc_we    = we_q;
  assign vdc_wdata = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vdc_host_seq.sv
// Directed bench for vdc_host_seq: table of single requests plus stall, reset-abort and address-cache sequences.
module tb_vdc_host_seq;

`ifdef VDC_HOST_ADDR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bus_en;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [5:0] req_reg = 6'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       vdc_cs, vdc_rs, vdc_we;
  logic [7:0] vdc_wdata;
  logic [7:0] vdc_rdata = 8'd0;
  logic [2:0] dbg_state;

  vdc_host_seq #(.POLL_TIMEOUT(4), .POLL_ALL(0)) dut (
    .clk(clk), .reset(reset), .bus_en(bus_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .vdc_cs(vdc_cs), .vdc_rs(vdc_rs), .vdc_we(vdc_we),
    .vdc_wdata(vdc_wdata), .vdc_rdata(vdc_rdata), .dbg_state(dbg_state)
  );

  // clock / bus strobe
  always #5 clk = ~clk;
  int cyc = 0;
  bit pulse_mode = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) bus_en <= pulse_mode ? (cyc % 4 == 0) : 1'b1;

  // VDC model: counts accesses, answers status/data reads one cycle later
  int n_sel = 0, n_stat = 0, n_drd = 0, n_dwr = 0;
  logic [7:0] last_sel = 8'd0, last_dwr = 8'd0;
  int stat_base = 0, busy_cfg = 0;
  logic [7:0] rd_val = 8'd0;
  always @(posedge clk) begin
    if (vdc_cs && !vdc_we && !vdc_rs) begin
      vdc_rdata <= ((n_stat - stat_base) < busy_cfg) ? 8'h7F : 8'h80;
      n_stat <= n_stat + 1;
    end else if (vdc_cs && !vdc_we && vdc_rs) begin
      vdc_rdata <= rd_val;
      n_drd <= n_drd + 1;
    end
    if (vdc_cs && vdc_we && bus_en) begin
      if (vdc_rs) begin n_dwr <= n_dwr + 1; last_dwr <= vdc_wdata; end
      else        begin n_sel <= n_sel + 1; last_sel <= vdc_wdata; end
    end
  end

  // scoreboard
  int n_checks = 0, n_pass = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    bit         we;
    logic [5:0] r;
    logic [7:0] wd;
    logic [7:0] rv;
    int         busy;
    int         lat;
    int         polls;
    bit         err;
    logic [7:0] rdata;
  } vec_t;

  int b_sel, b_stat, b_drd, b_dwr;

  task automatic setup(input int busy, input logic [7:0] rv);
    @(negedge clk);
    stat_base = n_stat; busy_cfg = busy; rd_val = rv;
    b_sel = n_sel; b_stat = n_stat; b_drd = n_drd; b_dwr = n_dwr;
  endtask

  // driver: issue one request, return cycles from acceptance to rsp_valid
  task automatic do_req(input bit we, input logic [5:0] r, input logic [7:0] wd,
                        output int lat, output logic [7:0] rd, output bit er, output int gaps);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_reg = r; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    chk("accept", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_drop", int'(req_ready), 0);
    lat = 1; gaps = 0;
    while (!rsp_valid && lat < 60) begin
      if (!vdc_cs) gaps++;
      @(negedge clk);
      lat++;
    end
    chk("rsp_seen", int'(rsp_valid), 1);
    rd = rsp_rdata; er = rsp_err;
    @(negedge clk);
    chk("rsp_pulse", int'(rsp_valid), 0);
    chk("ready_back", int'(req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int lat, gaps, seen;
    logic [7:0] rd;
    bit er;

    vecs[0] = '{1'b1, 6'd1,  8'h50, 8'h00, 0, 3,  0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 6'd26, 8'h00, 8'hF0, 0, 4,  0, 1'b0, 8'hF0};
    vecs[2] = '{1'b1, 6'd31, 8'hAA, 8'h00, 3, 11, 4, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 6'd18, 8'h11, 8'h00, 0, 5,  1, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 6'd33, 8'h00, 8'h5A, 2, 10, 3, 1'b0, 8'h5A};
    vecs[5] = '{1'b1, 6'd30, 8'hC3, 8'h00, 9, 10, 4, 1'b1, 8'h00};
    vecs[6] = '{1'b0, 6'd19, 8'h00, 8'h99, 9, 10, 4, 1'b1, 8'h00};
    vecs[7] = '{1'b0, 6'd5,  8'h00, 8'h3C, 0, 4,  0, 1'b0, 8'h3C};
    vecs[8] = '{1'b1, 6'd63, 8'hFF, 8'h00, 0, 3,  0, 1'b0, 8'h00};
    vecs[9] = '{1'b0, 6'd0,  8'h00, 8'h81, 0, 4,  0, 1'b0, 8'h81};

    // reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({req_ready, rsp_valid, rsp_err, rsp_rdata, vdc_cs, vdc_rs, vdc_we, vdc_wdata}), 0);
    chk("reset_state", int'(dbg_state), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(req_ready), 1);

    // table of single requests, bus_en held high
    for (int i = 0; i < 10; i++) begin
      setup(vecs[i].busy, vecs[i].rv);
      do_req(vecs[i].we, vecs[i].r, vecs[i].wd, lat, rd, er, gaps);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_err", i), int'(er), int'(vecs[i].err));
      chk($sformatf("v%0d_rdata", i), int'(rd), int'(vecs[i].rdata));
      chk($sformatf("v%0d_sel_count", i), n_sel - b_sel, 1);
      chk($sformatf("v%0d_sel_value", i), int'(last_sel), int'(vecs[i].r));
      chk($sformatf("v%0d_status_reads", i), n_stat - b_stat, vecs[i].polls);
      chk($sformatf("v%0d_data_reads", i), n_drd - b_drd, int'(!vecs[i].we && !vecs[i].err));
      chk($sformatf("v%0d_data_writes", i), n_dwr - b_dwr, int'(vecs[i].we && !vecs[i].err));
      if (vecs[i].we && !vecs[i].err)
        chk($sformatf("v%0d_wdata", i), int'(last_dwr), int'(vecs[i].wd));
    end

    // bus_en 1-in-4: SEL and write-DATA must hold cs until a strobe
    pulse_mode = 1'b1;
    setup(0, 8'h00);
    do_req(1'b1, 6'd2, 8'h77, lat, rd, er, gaps);
    chk("stall_sel_count", n_sel - b_sel, 1);
    chk("stall_write_count", n_dwr - b_dwr, 1);
    chk("stall_cs_held", gaps, 0);
    chk("stall_latency_range", int'(lat >= 6 && lat <= 9), 1);
    chk("stall_sel_value", int'(last_sel), 8'h02);
    chk("stall_wdata", int'(last_dwr), 8'h77);
    pulse_mode = 1'b0;

    // reset during POLL
    setup(9, 8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_reg = 6'd31; req_wdata = 8'h12;
    seen = 0;
    while (!req_ready && seen < 40) begin @(negedge clk); seen++; end
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    while (!(vdc_cs && !vdc_rs && !vdc_we) && seen < 20) begin @(negedge clk); seen++; end
    chk("poll_reached", int'(vdc_cs && !vdc_rs && !vdc_we), 1);
    reset = 1'b1;
    #1;
    chk("reset_cs_async", int'(vdc_cs), 0);
    chk("reset_state_async", int'(dbg_state), 0);
    seen = 0;
    repeat (3) begin @(negedge clk); if (rsp_valid) seen++; end
    reset = 1'b0;
    repeat (4) begin @(negedge clk); if (rsp_valid) seen++; end
    chk("reset_no_rsp", seen, 0);
    chk("reset_no_data_write", n_dwr - b_dwr, 0);
    setup(0, 8'h00);
    do_req(1'b1, 6'd4, 8'h44, lat, rd, er, gaps);
    chk("post_reset_latency", lat, 3);
    chk("post_reset_wdata", int'(last_dwr), 8'h44);

    // address cache: reg 12, reg 12, reg 13
    setup(0, 8'h00);
    do_req(1'b1, 6'd12, 8'h01, lat, rd, er, gaps);
    chk("cache_w1_sel", n_sel - b_sel, 1);
    chk("cache_w1_latency", lat, 3);
    setup(0, 8'h00);
    do_req(1'b1, 6'd12, 8'h02, lat, rd, er, gaps);
    chk("cache_w2_sel", n_sel - b_sel, CACHE ? 0 : 1);
    chk("cache_w2_latency", lat, CACHE ? 2 : 3);
    chk("cache_w2_wdata", int'(last_dwr), 8'h02);
    setup(0, 8'h00);
    do_req(1'b1, 6'd13, 8'h03, lat, rd, er, gaps);
    chk("cache_w3_sel", n_sel - b_sel, 1);
    chk("cache_w3_sel_value", int'(last_sel), 8'h0D);
    chk("cache_w3_latency", lat, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
